// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types: machine word and instruction opcodes.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  typedef enum logic [5:0] {
    RTYPE = 6'b000000,
    BEQ   = 6'b000100,
    ADDIU = 6'b001001,
    ORI   = 6'b001101,
    LUI   = 6'b001111,
    LW    = 6'b100011,
    SW    = 6'b101011,
    LL    = 6'b110000,
    SC    = 6'b111000,
    HALT  = 6'b111111
  } opcode_t;

endpackage

// File: rtl/my_types_pkg.sv
// Memory-stage FSM states and opcode classification helpers.
package my_types_pkg;
  import cpu_types_pkg::*;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } mem_state_t;

  function automatic logic is_load(opcode_t op);
    return (op == LW) || (op == LL);
  endfunction

  function automatic logic is_store(opcode_t op);
    return (op == SW) || (op == SC);
  endfunction

  function automatic logic is_mem(opcode_t op);
    return is_load(op) || is_store(op);
  endfunction

  function automatic word_t word_align(word_t a);
    return a & ~32'h3;
  endfunction

endpackage

// File: rtl/memory_access_stage_if.sv
// Dcache request/response bundle between the memory stage and the dcache.
interface memory_access_stage_if;
  import cpu_types_pkg::*;

  logic  dREN;
  logic  dWEN;
  word_t daddr;
  word_t dstore;
  logic  dhit;
  word_t dload;

  modport master (output dREN, dWEN, daddr, dstore, input dhit, dload);
  modport slave  (input dREN, dWEN, daddr, dstore, output dhit, dload);
endinterface

// File: rtl/link_reg.sv
// LL/SC reservation: one word address plus a valid bit, cleared by SC or a snoop.
module link_reg
  import cpu_types_pkg::*;
  import my_types_pkg::*;
(
  input  logic  CLK,
  input  logic  nRST,
  input  logic  set_i,
  input  logic  clr_i,
  input  word_t set_addr_i,
  input  logic  snoop_inv_i,
  input  word_t snoop_addr_i,
  output logic  link_valid_o,
  output word_t link_addr_o
);

  logic  valid_q, valid_d;
  word_t addr_q, addr_d;
  logic  snoop_hit;

  // Snoop is compared against the address being linked this cycle, so it wins over a set.
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    if (set_i) begin
      valid_d = 1'b1;
      addr_d  = set_addr_i;
    end
    if (clr_i) valid_d = 1'b0;
    snoop_hit = snoop_inv_i && (word_align(snoop_addr_i) == word_align(addr_d));
    if (snoop_hit) valid_d = 1'b0;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign link_valid_o = valid_q;
  assign link_addr_o  = addr_q;

endmodule

// File: rtl/memory_access_stage.sv
// Pipeline memory stage: issues dcache requests, stalls upstream, handles LL/SC and halt.
//   state  | meaning
//   IDLE   | inspect EX/MEM; pass non-memory ops, start access, or fail SC
//   ACCESS | dcache request held until dhit
//   DONE   | one-cycle MEM/WB update, upstream released
module memory_access_stage
  import cpu_types_pkg::*;
  import my_types_pkg::*;
(
  input  logic    CLK,
  input  logic    nRST,
  input  logic    op_valid,
  input  opcode_t op_code,
  input  word_t   alu_out,
  input  word_t   bus_b,
  input  logic    halt_in,
  memory_access_stage_if.master dc,
  input  logic    snoop_inv,
  input  word_t   snoop_addr,
  output word_t   read_data,
  output logic    mw_update,
  output logic    mw_flush,
  output logic    mem_stall,
  output logic    halt_out
);

  mem_state_t state_q, state_d;
  opcode_t    op_q, op_d;
  word_t      addr_q, addr_d;
  word_t      data_q, data_d;
  word_t      rd_q, rd_d;
  logic       halt_q, halt_d;
  logic       link_set, link_clr, link_valid, sc_ok;
  word_t      link_addr;

  link_reg u_link_reg (
    .CLK          (CLK),
    .nRST         (nRST),
    .set_i        (link_set),
    .clr_i        (link_clr),
    .set_addr_i   (addr_q),
    .snoop_inv_i  (snoop_inv),
    .snoop_addr_i (snoop_addr),
    .link_valid_o (link_valid),
    .link_addr_o  (link_addr)
  );

  assign sc_ok = link_valid && (word_align(link_addr) == word_align(alu_out));

  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    addr_d    = addr_q;
    data_d    = data_q;
    rd_d      = rd_q;
    halt_d    = halt_q;
    link_set  = 1'b0;
    link_clr  = 1'b0;
    dc.dREN   = 1'b0;
    dc.dWEN   = 1'b0;
    dc.daddr  = addr_q;
    dc.dstore = data_q;
    mw_update = 1'b0;
    mw_flush  = 1'b0;
    mem_stall = 1'b0;
    unique case (state_q)
      IDLE: begin
        mem_stall = op_valid && is_mem(op_code);
        if (!op_valid || halt_q) begin
          mw_flush = 1'b1;
        end else if (halt_in) begin
          halt_d    = 1'b1;
          mw_update = !is_mem(op_code);
        end else if (!is_mem(op_code)) begin
          mw_update = 1'b1;
        end else if ((op_code == SC) && !sc_ok) begin
          rd_d     = '0;
          link_clr = 1'b1;
          state_d  = DONE;
        end else begin
          op_d    = op_code;
          addr_d  = word_align(alu_out);
          data_d  = bus_b;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        mem_stall = 1'b1;
        dc.dREN   = is_load(op_q);
        dc.dWEN   = is_store(op_q);
        if (dc.dhit) begin
          state_d = DONE;
          if (is_load(op_q)) rd_d = dc.dload;
          else if (op_q == SC) rd_d = 32'd1;
          link_set = (op_q == LL);
          link_clr = (op_q == SC);
        end
      end
      DONE: begin
        mw_update = 1'b1;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (!nRST) begin
      dc.dREN   = 1'b0;
      dc.dWEN   = 1'b0;
      mw_update = 1'b0;
      mem_stall = 1'b0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= IDLE;
      op_q    <= RTYPE;
      addr_q  <= '0;
      data_q  <= '0;
      rd_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rd_q    <= rd_d;
      halt_q  <= halt_d;
    end
  end

  assign read_data = rd_q;
  assign halt_out  = halt_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Bench for memory_access_stage: directed vector table, LL/SC/snoop/reset/halt sequences, random ops.
module tb_memory_access_stage;
  import cpu_types_pkg::*;

  logic    CLK = 1'b0;
  logic    nRST;
  logic    op_valid, halt_in, snoop_inv;
  opcode_t op_code;
  word_t   alu_out, bus_b, snoop_addr, read_data;
  logic    mw_update, mw_flush, mem_stall, halt_out;

  memory_access_stage_if dc();

  memory_access_stage dut (
    .CLK        (CLK),
    .nRST       (nRST),
    .op_valid   (op_valid),
    .op_code    (op_code),
    .alu_out    (alu_out),
    .bus_b      (bus_b),
    .halt_in    (halt_in),
    .dc         (dc),
    .snoop_inv  (snoop_inv),
    .snoop_addr (snoop_addr),
    .read_data  (read_data),
    .mw_update  (mw_update),
    .mw_flush   (mw_flush),
    .mem_stall  (mem_stall),
    .halt_out   (halt_out)
  );

  always #5 CLK = ~CLK;

  int n_pass = 0;
  int n_total = 0;

  // reference model: reservation, last read_data, halt
  logic  lv_m;
  word_t la_m;
  word_t rd_m;
  logic  halt_m;

  typedef struct {
    opcode_t op;
    word_t   a;
    word_t   b;
    int      lat;
    word_t   ld;
    word_t   exp_rd;
    bit      exp_req;
  } vec_t;

  vec_t  tbl[10];
  word_t pool[4];

  task automatic chk1(input string name, input logic act, input logic exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input word_t act, input word_t exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Runs one instruction through the stage starting just after a rising edge.
  task automatic exec_op(input opcode_t op, input word_t a, input word_t b, input int lat,
                         input word_t ld, input bit snp, input word_t saddr, output bit saw_req);
    word_t wa;
    bit    is_ld, is_st, mem;
    wa    = a & ~32'h3;
    is_ld = (op == LW) || (op == LL);
    is_st = (op == SW) || (op == SC);
    mem   = is_ld || is_st;
    saw_req = 1'b0;
    op_valid = 1'b1; op_code = op; alu_out = a; bus_b = b; halt_in = 1'b0;
    snoop_inv = 1'b0; dc.dhit = 1'b0; dc.dload = ld;
    @(negedge CLK);
    saw_req = dc.dREN | dc.dWEN;
    chk1("idle_dREN", dc.dREN, 1'b0);
    chk1("idle_dWEN", dc.dWEN, 1'b0);
    if (halt_m) begin
      chk1("halted_update", mw_update, 1'b0);
      chk1("halted_out", halt_out, 1'b1);
      step();
      return;
    end
    chk1("idle_flush", mw_flush, 1'b0);
    if (!mem) begin
      chk1("pass_update", mw_update, 1'b1);
      chk1("pass_stall", mem_stall, 1'b0);
      chk32("pass_rdata", read_data, rd_m);
      step();
      return;
    end
    chk1("idle_stall", mem_stall, 1'b1);
    chk1("idle_update", mw_update, 1'b0);
    if (op == SC && !(lv_m && la_m == wa)) begin
      step();
      @(negedge CLK);
      saw_req |= dc.dREN | dc.dWEN;
      rd_m = '0;
      lv_m = 1'b0;
      chk1("scfail_update", mw_update, 1'b1);
      chk1("scfail_stall", mem_stall, 1'b0);
      chk1("scfail_dWEN", dc.dWEN, 1'b0);
      chk32("scfail_rdata", read_data, rd_m);
      step();
      return;
    end
    for (int i = 0; i < lat; i++) begin
      step();
      dc.dhit = (i == lat - 1);
      if (i == lat - 1 && snp) begin
        snoop_inv = 1'b1;
        snoop_addr = saddr;
      end
      @(negedge CLK);
      saw_req |= dc.dREN | dc.dWEN;
      chk1("acc_dREN", dc.dREN, is_ld);
      chk1("acc_dWEN", dc.dWEN, is_st);
      chk32("acc_daddr", dc.daddr, wa);
      if (is_st) chk32("acc_dstore", dc.dstore, b);
      chk1("acc_stall", mem_stall, 1'b1);
      chk1("acc_update", mw_update, 1'b0);
    end
    step();
    dc.dhit = 1'b0;
    snoop_inv = 1'b0;
    if (is_ld) rd_m = ld;
    if (op == SC) rd_m = 32'd1;
    if (op == LL) begin
      lv_m = 1'b1;
      la_m = wa;
    end
    if (op == SC) lv_m = 1'b0;
    if (snp && ((saddr & ~32'h3) == la_m)) lv_m = 1'b0;
    @(negedge CLK);
    chk1("done_update", mw_update, 1'b1);
    chk1("done_stall", mem_stall, 1'b0);
    chk1("done_dREN", dc.dREN, 1'b0);
    chk1("done_dWEN", dc.dWEN, 1'b0);
    chk32("done_rdata", read_data, rd_m);
    step();
  endtask

  task automatic idle_cycle(input bit snp, input word_t saddr);
    op_valid = 1'b0; halt_in = 1'b0; snoop_inv = snp; snoop_addr = saddr;
    @(negedge CLK);
    chk1("bubble_flush", mw_flush, 1'b1);
    chk1("bubble_update", mw_update, 1'b0);
    chk1("bubble_stall", mem_stall, 1'b0);
    chk1("bubble_dREN", dc.dREN, 1'b0);
    chk1("bubble_dWEN", dc.dWEN, 1'b0);
    step();
    snoop_inv = 1'b0;
    if (snp && ((saddr & ~32'h3) == la_m)) lv_m = 1'b0;
  endtask

  initial begin
    bit req;
    lv_m = 1'b0; la_m = '0; rd_m = '0; halt_m = 1'b0;
    pool[0] = 32'h80; pool[1] = 32'h84; pool[2] = 32'h100; pool[3] = 32'h200;

    tbl[0] = '{LW,    32'h104, 32'h0,        3, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1};
    tbl[1] = '{SW,    32'h203, 32'h12345678, 2, 32'h0,        32'hDEADBEEF, 1'b1};
    tbl[2] = '{RTYPE, 32'h5,   32'h0,        1, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[3] = '{LL,    32'h80,  32'h0,        1, 32'hCAFE0001, 32'hCAFE0001, 1'b1};
    tbl[4] = '{SC,    32'h80,  32'h77,       2, 32'h0,        32'h1,        1'b1};
    tbl[5] = '{SC,    32'h80,  32'h78,       1, 32'h0,        32'h0,        1'b0};
    tbl[6] = '{LW,    32'h3FC, 32'h0,        1, 32'h0,        32'h0,        1'b1};
    tbl[7] = '{ORI,   32'h9,   32'h0,        1, 32'h0,        32'h0,        1'b0};
    tbl[8] = '{LL,    32'h84,  32'h0,        1, 32'h11,       32'h11,       1'b1};
    tbl[9] = '{SC,    32'h87,  32'h5,        1, 32'h0,        32'h1,        1'b1};

    // reset with a memory op presented: everything must stay quiet
    nRST = 1'b0; op_valid = 1'b1; op_code = LW; alu_out = 32'h104; bus_b = '0;
    halt_in = 1'b0; snoop_inv = 1'b0; snoop_addr = '0; dc.dhit = 1'b0; dc.dload = '0;
    step();
    @(negedge CLK);
    chk1("rst_dREN", dc.dREN, 1'b0);
    chk1("rst_dWEN", dc.dWEN, 1'b0);
    chk1("rst_update", mw_update, 1'b0);
    chk1("rst_stall", mem_stall, 1'b0);
    chk32("rst_rdata", read_data, 32'h0);
    chk1("rst_halt", halt_out, 1'b0);
    step();
    nRST = 1'b1;
    idle_cycle(1'b0, '0);

    foreach (tbl[k]) begin
      exec_op(tbl[k].op, tbl[k].a, tbl[k].b, tbl[k].lat, tbl[k].ld, 1'b0, '0, req);
      chk32("tbl_rdata", read_data, tbl[k].exp_rd);
      chk1("tbl_req", req, tbl[k].exp_req);
    end

    // snoop on the linked word kills the SC
    exec_op(LL, 32'h80, 32'h0, 1, 32'h5A5A, 1'b0, '0, req);
    idle_cycle(1'b1, 32'h82);
    exec_op(SC, 32'h80, 32'h9, 1, 32'h0, 1'b0, '0, req);
    chk32("snoop_sc_rdata", read_data, 32'h0);
    chk1("snoop_sc_req", req, 1'b0);

    // snoop to another word leaves the link intact
    exec_op(LL, 32'h400, 32'h0, 2, 32'h1, 1'b0, '0, req);
    idle_cycle(1'b1, 32'h404);
    exec_op(SC, 32'h400, 32'h9, 1, 32'h0, 1'b0, '0, req);
    chk32("snoop_other_rdata", read_data, 32'h1);
    chk1("snoop_other_req", req, 1'b1);

    // snoop in the same cycle as the LL completes wins
    exec_op(LL, 32'h300, 32'h0, 2, 32'h22, 1'b1, 32'h301, req);
    exec_op(SC, 32'h300, 32'h9, 1, 32'h0, 1'b0, '0, req);
    chk1("snoop_race_req", req, 1'b0);
    chk32("snoop_race_rdata", read_data, 32'h0);

    // random traffic against the model
    for (int n = 0; n < 150; n++) begin
      int    r;
      word_t a, sa;
      opcode_t op;
      r  = $urandom_range(0, 9);
      a  = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      sa = pool[$urandom_range(0, 3)] + 32'($urandom_range(0, 3));
      if (r == 9) begin
        idle_cycle($urandom_range(0, 2) == 0, sa);
      end else begin
        case (r)
          0, 1:    op = LW;
          2:       op = SW;
          3, 4:    op = LL;
          5, 6:    op = SC;
          7:       op = RTYPE;
          default: op = ADDIU;
        endcase
        exec_op(op, a, $urandom, $urandom_range(1, 4), $urandom,
                $urandom_range(0, 3) == 0, sa, req);
      end
    end

    // reset in the middle of an access
    exec_op(LL, 32'h80, 32'h0, 1, 32'h7, 1'b0, '0, req);
    op_valid = 1'b1; op_code = LW; alu_out = 32'h104; dc.dhit = 1'b0;
    @(negedge CLK);
    chk1("mid_idle_stall", mem_stall, 1'b1);
    step();
    @(negedge CLK);
    chk1("mid_acc_dREN", dc.dREN, 1'b1);
    step();
    nRST = 1'b0;
    @(negedge CLK);
    chk1("mid_rst_dREN", dc.dREN, 1'b0);
    chk1("mid_rst_update", mw_update, 1'b0);
    chk1("mid_rst_stall", mem_stall, 1'b0);
    step();
    nRST = 1'b1;
    lv_m = 1'b0; rd_m = '0; halt_m = 1'b0;
    op_valid = 1'b0;
    @(negedge CLK);
    chk32("mid_after_rdata", read_data, 32'h0);
    chk1("mid_after_flush", mw_flush, 1'b1);
    chk1("mid_after_dREN", dc.dREN, 1'b0);
    chk1("mid_after_update", mw_update, 1'b0);
    step();
    exec_op(SC, 32'h80, 32'h1, 1, 32'h0, 1'b0, '0, req);
    chk1("mid_link_cleared", req, 1'b0);

    // halt is sticky and blocks further dcache traffic
    op_valid = 1'b1; op_code = HALT; halt_in = 1'b1;
    @(negedge CLK);
    chk1("halt_update", mw_update, 1'b1);
    chk1("halt_not_yet", halt_out, 1'b0);
    step();
    halt_in = 1'b0;
    halt_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      exec_op(LW, 32'h104, 32'h0, 1, 32'h1, 1'b0, '0, req);
      chk1("halt_no_req", req, 1'b0);
    end
    idle_cycle(1'b0, '0);
    @(negedge CLK);
    chk1("halt_sticky", halt_out, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/memory_access_stage.md
MEMORY_ACCESS_STAGE -- requirements
Module: memory_access_stage

Interface
REQ-001 SHALL have port CLK  in  1  pipeline clock; all state updates on rising edge.
REQ-002 SHALL have port nRST  in  1  reset, synchronous and active-low.
REQ-003 SHALL have port op_valid  in  1  EX/MEM latch holds a live instruction.
REQ-004 SHALL have port op_code  in  opcode_t  instruction opcode from EX/MEM.
REQ-005 SHALL have port alu_out  in  word_t  effective address / ALU result.
REQ-006 SHALL have port bus_b  in  word_t  store data.
REQ-007 SHALL have port halt_in  in  1  halt marker from EX/MEM.
REQ-008 SHALL have ports dREN, dWEN  out  1 each  dcache read/write request.
REQ-009 SHALL have ports daddr, dstore  out  word_t  dcache address, store data.
REQ-010 SHALL have ports dhit  in  1 and dload  in  word_t  dcache completion and load data.
REQ-011 SHALL have ports snoop_inv  in  1 and snoop_addr  in  word_t  coherence invalidation from the other core.
REQ-012 SHALL have port read_data  out  word_t  value for MEM/WB read_data_in.
REQ-013 SHALL have ports mw_update, mw_flush  out  1 each  MEM/WB latch update/bubble controls.
REQ-014 SHALL have port mem_stall  out  1  freeze upstream stages.
REQ-015 SHALL have port halt_out  out  1  sticky halt indication.

Function
REQ-016 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-017 IDLE: op_valid with LW/LL/SW -> ACCESS next edge; SC with valid matching link -> ACCESS; SC without valid match -> DONE with read_data=0, no dcache request.
REQ-018 ACCESS: dREN=1 for LW/LL, dWEN=1 for SW/SC, daddr={alu_out[31:2],2'b00}, dstore=bus_b; requests held stable until dhit.
REQ-019 ACCESS with dhit: capture dload into read_data (LW/LL) or 1 (SC), SW leaves read_data unchanged; -> DONE next edge; dREN/dWEN deasserted from that edge.
REQ-020 DONE: mw_update=1 for exactly one cycle, mem_stall=0, -> IDLE next edge.
REQ-021 mem_stall SHALL equal 1 when (IDLE and op_valid and memory op) or state==ACCESS; 0 otherwise.
REQ-022 Non-memory valid op in IDLE: mw_update=1 same cycle (combinational), no dcache request, read_data unchanged.
REQ-023 op_valid=0 in IDLE: mw_flush=1, mw_update=0.
REQ-024 Minimum memory-op latency: request cycle N+1, dhit earliest N+1, mw_update at N+2.
REQ-025 Link register: LL completion sets link_valid=1, link_addr=daddr; any SC completion (success or failure) clears link_valid.
REQ-026 snoop_inv with snoop_addr word-address equal to link_addr clears link_valid; snoop wins over simultaneous LL set.
REQ-027 halt_in with op_valid in IDLE sets halt_out=1, sticky until reset; while halt_out=1 no dcache request is issued and mw_update=0.
REQ-028 dREN and dWEN SHALL never be asserted simultaneously.

Reset
REQ-029 nRST low at a rising edge: state=IDLE, read_data=0, link_valid=0, link_addr=0, halt_out=0, including mid-ACCESS (request drops from that edge).
REQ-030 During reset: dREN=dWEN=0, mw_update=0, mem_stall=0.

Structure
REQ-031 mem_state_t enum and LL/SC opcode helpers SHALL live in my_types_pkg; opcode_t, word_t from cpu_types_pkg.
REQ-032 link register logic SHALL be sub-module link_reg (set, clear, snoop compare, valid/addr outputs).

Verification
REQ-033 LW alu_out=0x104, dhit after 3 cycles with dload=0xDEADBEEF -> dREN 3 cycles, daddr=0x104, read_data=0xDEADBEEF, one mw_update pulse, mem_stall deasserted in DONE.
REQ-034 SW alu_out=0x203, bus_b=0x12345678 -> daddr=0x200, dstore=0x12345678, dWEN until dhit, dREN=0 throughout.
REQ-035 LL 0x80 then SC 0x80 -> SC writes, read_data=1; second SC 0x80 -> no dWEN, read_data=0.
REQ-036 LL 0x80, snoop_inv snoop_addr=0x82, then SC 0x80 -> SC fails, read_data=0, no dWEN.
REQ-037 nRST low during ACCESS -> dREN=0 next cycle, state IDLE, link_valid=0, no mw_update.
REQ-038 halt_in with op_valid -> halt_out=1 sticky; subsequent LW issues no dREN.
